// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - handshake bundle between main control, Mult/Div units and the sequencer
interface muldiv_sequencer_if;
    logic start;
    logic op_div;
    logic abort;
    logic mult_done;
    logic div_done;
    logic div0;
    logic mult_ctrl;
    logic div_ctrl;
    logic hi_ctrl;
    logic lo_ctrl;
    logic write_hi;
    logic write_lo;
    logic busy;
    logic done;
    logic div0_exc;
    logic timeout_exc;

    modport master (
        output start, op_div, abort, mult_done, div_done, div0,
        input  mult_ctrl, div_ctrl, hi_ctrl, lo_ctrl, write_hi, write_lo,
               busy, done, div0_exc, timeout_exc
    );

    modport slave (
        input  start, op_div, abort, mult_done, div_done, div0,
        output mult_ctrl, div_ctrl, hi_ctrl, lo_ctrl, write_hi, write_lo,
               busy, done, div0_exc, timeout_exc
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - launches Mult/Div, watchdogs completion, writes HI/LO or raises an exception
module muldiv_sequencer #(
    parameter int TIMEOUT = 48
) (
    input  logic               clock,
    input  logic               reset,
    muldiv_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT_RUN,
        S_DIV_RUN,
        S_WRITE,
        S_EXC
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       op_q, op_d;
    logic       div0_cause_q, div0_cause_d;
    logic       tmo_cause_q, tmo_cause_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            op_q         <= 1'b0;
            div0_cause_q <= 1'b0;
            tmo_cause_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            div0_cause_q <= div0_cause_d;
            tmo_cause_q  <= tmo_cause_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        div0_cause_d = div0_cause_q;
        tmo_cause_d  = tmo_cause_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op_div;
                    cnt_d   = 8'd0;
                    state_d = bus.op_div ? S_DIV_RUN : S_MULT_RUN;
                end
            end
            S_MULT_RUN: begin
                if (bus.mult_done) begin
                    state_d = S_WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = S_EXC;
                    div0_cause_d = 1'b0;
                    tmo_cause_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DIV_RUN: begin
                if (bus.div0) begin
                    state_d      = S_EXC;
                    div0_cause_d = 1'b1;
                    tmo_cause_d  = 1'b0;
                end else if (bus.div_done) begin
                    state_d = S_WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = S_EXC;
                    div0_cause_d = 1'b0;
                    tmo_cause_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_EXC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Cancellation overrides every transition, including a start in IDLE.
        if (bus.abort) begin
            state_d = S_IDLE;
        end
    end

    // Mux selects follow the latched op so they stay put from the first run cycle through WRITE.
    assign bus.mult_ctrl   = (state_q == S_MULT_RUN);
    assign bus.div_ctrl    = (state_q == S_DIV_RUN);
    assign bus.hi_ctrl     = ~op_q;
    assign bus.lo_ctrl     = ~op_q;
    assign bus.write_hi    = (state_q == S_WRITE);
    assign bus.write_lo    = (state_q == S_WRITE);
    assign bus.done        = (state_q == S_WRITE);
    assign bus.div0_exc    = (state_q == S_EXC) & div0_cause_q;
    assign bus.timeout_exc = (state_q == S_EXC) & tmo_cause_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - vector table, hand sequences and randomized model checks for muldiv_sequencer
module tb_muldiv_sequencer;
    localparam int T = 48;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    muldiv_sequencer_if bus ();

    muldiv_sequencer #(.TIMEOUT(T)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit op;
        int dk;
        int zk;
        int ak;
        bit xd;
        bit sb;
        int exp_run;
        int exp_busy;
        int exp_wr;
        int exp_d0;
        int exp_to;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.start     = 1'b0;
        bus.op_div    = 1'b0;
        bus.abort     = 1'b0;
        bus.mult_done = 1'b0;
        bus.div_done  = 1'b0;
        bus.div0      = 1'b0;
    endtask

    // Earliest event ends the run; at equal cycles abort > div0 > done > watchdog.
    task automatic model(input bit op, input int dk, input int zk, input int ak,
                         output int run, output int busy, output int wr,
                         output int d0, output int to);
        int k;
        int res;
        k = T; res = 3;
        if (dk > 0 && dk <= k) begin k = dk; res = 0; end
        if (op && zk > 0 && zk <= k) begin k = zk; res = 1; end
        if (ak > 0 && ak <= k) begin k = ak; res = 2; end
        run  = k;
        busy = (res == 2) ? k : k + 1;
        wr   = (res == 0) ? 1 : 0;
        d0   = (res == 1) ? 1 : 0;
        to   = (res == 3) ? 1 : 0;
    endtask

    // Called at #1 after a posedge with the DUT idle; returns when it is idle again.
    task automatic run_op(input string tag, input bit op, input int dk, input int zk,
                          input int ak, input bit xd, input bit sb,
                          input int e_run, input int e_busy, input int e_wr,
                          input int e_d0, input int e_to);
        int run_c, busy_c, wr_c, done_c, d0_c, to_c, sel_bad, other_bad, clash;
        int k;
        bit fin;
        run_c = 0; busy_c = 0; wr_c = 0; done_c = 0; d0_c = 0; to_c = 0;
        sel_bad = 0; other_bad = 0; clash = 0; fin = 0;
        bus.start  = 1'b1;
        bus.op_div = op;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (k = 1; k <= 300; k++) begin
            if (!bus.busy) begin
                fin = 1;
                break;
            end
            busy_c++;
            if (op ? bus.div_ctrl : bus.mult_ctrl) run_c++;
            if (op ? bus.mult_ctrl : bus.div_ctrl) other_bad++;
            if (bus.hi_ctrl != !op || bus.lo_ctrl != !op) sel_bad++;
            if (bus.write_hi && bus.write_lo) wr_c++;
            if (bus.done) done_c++;
            if (bus.div0_exc) d0_c++;
            if (bus.timeout_exc) to_c++;
            if ((bus.div0_exc || bus.timeout_exc) && (bus.write_hi || bus.write_lo)) clash++;
            bus.mult_done = (!op && dk == k) || (op && xd);
            bus.div_done  = (op && dk == k) || (!op && xd);
            bus.div0      = (zk == k);
            bus.abort     = (ak == k);
            bus.start     = sb;
            bus.op_div    = sb ? 1'($urandom_range(0, 1)) : op;
            @(posedge clock); #1;
        end
        clear_inputs();
        check({tag, " finished"}, int'(fin), 1);
        check({tag, " run cycles"}, run_c, e_run);
        check({tag, " busy cycles"}, busy_c, e_busy);
        check({tag, " writes"}, wr_c, e_wr);
        check({tag, " done pulses"}, done_c, e_wr);
        check({tag, " div0_exc pulses"}, d0_c, e_d0);
        check({tag, " timeout_exc pulses"}, to_c, e_to);
        check({tag, " hi/lo select errors"}, sel_bad, 0);
        check({tag, " wrong unit enabled"}, other_bad, 0);
        check({tag, " exception with write"}, clash, 0);
    endtask

    vec_t vecs[9];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        //              op dk  zk  ak xd sb run busy wr d0 to
        vecs[0] = '{0, 33, 0,  0, 0, 0, 33, 34, 1, 0, 0};
        vecs[1] = '{1, 32, 0,  0, 0, 0, 32, 33, 1, 0, 0};
        vecs[2] = '{1, 1,  1,  0, 0, 0, 1,  2,  0, 1, 0};
        vecs[3] = '{0, 0,  0,  0, 0, 0, 48, 49, 0, 0, 1};
        vecs[4] = '{0, 0,  0, 10, 0, 1, 10, 10, 0, 0, 0};
        vecs[5] = '{1, 48, 0,  0, 0, 0, 48, 49, 1, 0, 0};
        vecs[6] = '{0, 0,  0,  0, 1, 0, 48, 49, 0, 0, 1};
        vecs[7] = '{1, 0, 48,  0, 0, 0, 48, 49, 0, 1, 0};
        vecs[8] = '{0, 1,  0,  0, 0, 1, 1,  2,  1, 0, 0};

        clear_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset busy", int'(bus.busy), 0);
        check("reset mult_ctrl", int'(bus.mult_ctrl), 0);
        check("reset div_ctrl", int'(bus.div_ctrl), 0);
        check("reset write_hi", int'(bus.write_hi), 0);
        check("reset done", int'(bus.done), 0);
        check("reset exc", int'(bus.div0_exc | bus.timeout_exc), 0);
        check("reset hi_ctrl", int'(bus.hi_ctrl), 1);
        check("reset lo_ctrl", int'(bus.lo_ctrl), 1);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].dk, vecs[i].zk, vecs[i].ak,
                   vecs[i].xd, vecs[i].sb, vecs[i].exp_run, vecs[i].exp_busy,
                   vecs[i].exp_wr, vecs[i].exp_d0, vecs[i].exp_to);
        end

        // start together with abort in IDLE is dropped
        bus.start = 1'b1; bus.op_div = 1'b1; bus.abort = 1'b1;
        @(posedge clock); #1;
        clear_inputs();
        check("start+abort idle busy", int'(bus.busy), 0);
        check("start+abort idle div_ctrl", int'(bus.div_ctrl), 0);

        // done flags seen in IDLE do nothing
        bus.mult_done = 1'b1; bus.div_done = 1'b1; bus.div0 = 1'b1;
        @(posedge clock); #1;
        clear_inputs();
        check("idle done ignored busy", int'(bus.busy), 0);
        check("idle done ignored write", int'(bus.write_hi), 0);

        // asynchronous reset in the middle of DIV_RUN
        bus.start = 1'b1; bus.op_div = 1'b1;
        @(posedge clock); #1;
        clear_inputs();
        repeat (3) @(posedge clock);
        #1;
        check("pre-reset div_ctrl", int'(bus.div_ctrl), 1);
        check("pre-reset hi_ctrl", int'(bus.hi_ctrl), 0);
        reset = 1'b0;
        #1;
        check("async reset div_ctrl", int'(bus.div_ctrl), 0);
        check("async reset busy", int'(bus.busy), 0);
        check("async reset hi_ctrl", int'(bus.hi_ctrl), 1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("post-reset busy", int'(bus.busy), 0);

        // randomized runs against the event model
        for (int r = 0; r < 30; r++) begin
            bit op, xd, sb;
            int dk, zk, ak, e_run, e_busy, e_wr, e_d0, e_to;
            op = 1'($urandom_range(0, 1));
            xd = ($urandom_range(0, 3) == 0);
            sb = 1'($urandom_range(0, 1));
            dk = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, T + 2));
            zk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, T)) : 0;
            ak = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, T)) : 0;
            model(op, dk, zk, ak, e_run, e_busy, e_wr, e_d0, e_to);
            run_op($sformatf("rnd%0d", r), op, dk, zk, ak, xd, sb,
                   e_run, e_busy, e_wr, e_d0, e_to);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
